pulpino_boot_seq: RTL
=====================

Name: pulpino_boot_seq

Overview:
- FPGA-side boot sequencer that sits directly upstream of the PULPino top wrapper and drives its `rst_n` and `fetch_enable_i` inputs.
- Synchronises and debounces the board reset and fetch push-buttons.
- Holds the core in reset for a fixed time after power-up or a button press.
- Releases fetch either on a button press or automatically once the SPI-slave boot loader has been idle for a set time.

Parameters:
RST_HOLD_CYCLES, 1024, number of cycles `core_rst_no` is held low in HOLD (minimum 2)
DEB_CYCLES, 65536, number of cycles a button level must stay stable before it is accepted (minimum 2)
FETCH_DELAY, 256, number of consecutive cycles with `spi_cs_i` high in IDLE before auto-fetch (minimum 1)
AUTO_FETCH, 1, 1 = auto-fetch enabled; 0 = fetch only via `fetch_btn_i`

Ports:
clk  in  1  system clock, same domain as the PULPino wrapper
rst_n  in  1  synchronous active-low reset
ext_rst_btn_i  in  1  board reset button, active high, asynchronous
fetch_btn_i  in  1  board fetch button, active high, asynchronous
spi_cs_i  in  1  SPI-slave chip select seen by the wrapper, active low, asynchronous
core_rst_no  out  1  drives the wrapper `rst_n`; active low
fetch_enable_o  out  1  drives the wrapper `fetch_enable_i`
state_o  out  2  FSM state: 00 HOLD, 01 IDLE, 10 RUN
boot_count_o  out  8  number of button-initiated core resets, saturating at 255

Behaviour:
- Interface decision: one clock, `clk`; reset `rst_n` is synchronous and active-low. All flops, including the synchronisers, are reset only on a `clk` edge with `rst_n`=0.
- Synchronisers: a 2-flop synchroniser on each asynchronous input.
  - Reset values: button syncs 0; `spi_cs` sync 1.
- Debouncer, one per button:
  - State is a debounced level (reset 0) plus a counter (reset 0).
  - If the synced level differs from the debounced level, the counter increments.
  - When the counter reaches DEB_CYCLES-1 on a differing cycle, the debounced level toggles and the counter clears.
  - Any cycle where the levels match clears the counter.
  - Total latency from a pin edge to the debounced edge is 2 + DEB_CYCLES cycles.
- Edge pulses: a debounced rising edge generates a one-cycle internal pulse (`rst_pulse`, `fetch_pulse`). Falling edges generate nothing.
- FSM, with reset state HOLD:
  - HOLD: `core_rst_no`=0, `fetch_enable_o`=0.
    - `hold_cnt` increments each cycle while the debounced reset button is low, and is held at 0 while it is high.
    - When `hold_cnt` reaches RST_HOLD_CYCLES-1, go to IDLE.
  - IDLE: `core_rst_no`=1, `fetch_enable_o`=0.
    - `idle_cnt` increments while synced `spi_cs`=1 and clears to 0 whenever synced `spi_cs`=0.
    - Go to RUN on `fetch_pulse`.
    - Also go to RUN if AUTO_FETCH=1 and `idle_cnt` reaches FETCH_DELAY-1.
  - RUN: `core_rst_no`=1, `fetch_enable_o`=1.
    - Ignore `fetch_pulse` and `spi_cs`.
    - Stay in RUN until `rst_pulse`.
  - `rst_pulse` in any state: next state is HOLD, `hold_cnt` and `idle_cnt` clear, and `boot_count_o` increments, saturating at 255 (holds at 255).
- Priority: `rst_pulse` beats `fetch_pulse`, the auto-fetch timeout and the HOLD timeout in the same cycle.
- Register timing: all outputs are registered.
  - `core_rst_no` and `fetch_enable_o` change on the cycle the state register updates.
  - No glitches on either output.
- Counter widths: each counter is `$clog2(param)` bits; counters never wrap past their terminal value.
- Reset mid-operation: `rst_n`=0 on any cycle forces the state to HOLD and all counters, debounced levels and `boot_count_o` to 0. Outputs become `core_rst_no`=0, `fetch_enable_o`=0, `state_o`=00 on the next edge.
- Unused state encoding 11: decode as HOLD and transition per HOLD rules.

Test Plan:
(all tests use DEB_CYCLES=4, RST_HOLD_CYCLES=8, FETCH_DELAY=5)
- Power-up, AUTO_FETCH=1, `spi_cs_i`=1 throughout, release `rst_n` -> `core_rst_no` rises 8 cycles after release, then `fetch_enable_o` rises 5 cycles later; `state_o` goes 00->01->10; `boot_count_o`=0.
- AUTO_FETCH=1, pulse `spi_cs_i` low for 3 cycles at IDLE entry +3 -> auto-fetch counter restarts; `fetch_enable_o` rises 5 cycles after synced `spi_cs` returns high.
- AUTO_FETCH=0, press `fetch_btn_i` with 2-cycle bounce then a stable high -> exactly one transition to RUN, 2+4 cycles after the stable edge; bounce shorter than 4 cycles produces no pulse.
- In RUN, press `ext_rst_btn_i` and hold for 20 cycles -> `core_rst_no` and `fetch_enable_o` drop together 6 cycles after the press; HOLD lasts until 8 cycles after the debounced release; `boot_count_o`=1.
- Same cycle `rst_pulse` and `fetch_pulse` in IDLE -> state goes to HOLD, `fetch_enable_o` stays 0; 256 reset presses -> `boot_count_o` saturates at 255.
- Assert `rst_n`=0 for 1 cycle while in RUN -> next edge gives `core_rst_no`=0, `fetch_enable_o`=0, `state_o`=00, `boot_count_o`=0.

Source files
------------

// File: rtl/pulpino_boot_seq.sv
// pulpino_boot_seq: FPGA-side boot sequencer feeding the PULPino wrapper.
// Synchronises and debounces the reset/fetch buttons, holds the core in reset
// for a fixed time, then releases fetch on a button press or, optionally,
// once the SPI-slave boot loader has been idle long enough.
//
// Ports:
//   clk            system clock (wrapper domain)
//   rst_n          synchronous active-low reset
//   ext_rst_btn_i  board reset button, active high, asynchronous
//   fetch_btn_i    board fetch button, active high, asynchronous
//   spi_cs_i       SPI-slave chip select, active low, asynchronous
//   core_rst_no    wrapper rst_n, active low, registered
//   fetch_enable_o wrapper fetch_enable_i, registered
//   state_o        FSM state: 00 HOLD, 01 IDLE, 10 RUN
//   boot_count_o   button-initiated core resets, saturating at 255
module pulpino_boot_seq #(
  parameter int unsigned RST_HOLD_CYCLES = 1024,
  parameter int unsigned DEB_CYCLES      = 65536,
  parameter int unsigned FETCH_DELAY     = 256,
  parameter bit          AUTO_FETCH      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_rst_btn_i,
  input  logic       fetch_btn_i,
  input  logic       spi_cs_i,
  output logic       core_rst_no,
  output logic       fetch_enable_o,
  output logic [1:0] state_o,
  output logic [7:0] boot_count_o
);

  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned IDLE_W = (FETCH_DELAY > 1) ? $clog2(FETCH_DELAY) : 1;
  localparam int unsigned BOOT_W = 8;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FETCH_DELAY - 1);
  localparam logic [BOOT_W-1:0] BOOT_MAX = {BOOT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  // Two-flop synchronisers; chip select idles high so its sync resets to 1.
  logic [1:0] rst_sync;
  logic [1:0] fetch_sync;
  logic [1:0] cs_sync;
  logic       cs_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_sync   <= 2'b00;
      fetch_sync <= 2'b00;
      cs_sync    <= 2'b11;
    end else begin
      rst_sync   <= {rst_sync[0], ext_rst_btn_i};
      fetch_sync <= {fetch_sync[0], fetch_btn_i};
      cs_sync    <= {cs_sync[0], spi_cs_i};
    end
  end

  assign cs_s = cs_sync[1];

  // Debouncers: index 0 = reset button, index 1 = fetch button.
  logic [1:0]       btn_s;
  logic [1:0]       deb_lvl_q;
  logic [1:0]       deb_lvl_d;
  logic [1:0]       deb_rise_c;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic             rst_pulse;
  logic             fetch_pulse;
  logic             rst_lvl;

  assign btn_s = {fetch_sync[1], rst_sync[1]};

  // A level is accepted after DEB_CYCLES consecutive differing cycles; the
  // rising-edge pulse is taken from the toggle itself so the FSM reacts on
  // the same edge the debounced level changes.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i]  = '0;
      deb_lvl_d[i]  = deb_lvl_q[i];
      deb_rise_c[i] = 1'b0;
      if (btn_s[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          deb_lvl_d[i]  = ~deb_lvl_q[i];
          deb_rise_c[i] = ~deb_lvl_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_lvl_q    <= 2'b00;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      deb_lvl_q    <= deb_lvl_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
    end
  end

  assign rst_pulse   = deb_rise_c[0];
  assign fetch_pulse = deb_rise_c[1];
  assign rst_lvl     = deb_lvl_q[0];

  // Boot FSM and its counters.
  state_t              state_q;
  state_t              state_d;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_d;
  logic [BOOT_W-1:0]   boot_cnt_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    idle_cnt_d = '0;
    boot_cnt_d = boot_count_o;

    case (state_q)
      ST_IDLE: begin
        // Counts consecutive synced-high chip-select cycles, saturating.
        if (cs_s) begin
          idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        end
        if (fetch_pulse || (AUTO_FETCH && cs_s && (idle_cnt_q == IDLE_MAX))) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        // HOLD, and the unused encoding folded into HOLD.
        state_d = ST_HOLD;
        if (!rst_lvl) begin
          if (hold_cnt_q == HOLD_MAX) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
    endcase

    // A reset press overrides every other transition.
    if (rst_pulse) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
      if (boot_count_o != BOOT_MAX) begin
        boot_cnt_d = boot_count_o + BOOT_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they switch with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      boot_count_o   <= '0;
      core_rst_no    <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      boot_count_o   <= boot_cnt_d;
      core_rst_no    <= (state_d != ST_HOLD);
      fetch_enable_o <= (state_d == ST_RUN);
    end
  end

  assign state_o = state_q;

endmodule
